apb_rr_arbiter: RTL and testbench

//   Shares the single APB master port among NUM_REQ requesters using round-robin arbitration.

---
 rtl/apb_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/apb_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : apb_arb_pkg
// Brief    : Shared types, defaults and helpers for the APB round-robin arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_arb_pkg;

    // Bus sequencing states: IDLE picks a winner, SETUP/ACCESS run the APB phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Fold an index in [0, 2n) back into [0, n); enough for one round-robin lap.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Returns the first eligible
//            requester at or after ptr+1 (wrapping) as one-hot and as an index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan one full lap starting just after the last grant; first hit wins.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'(wrap_idx(int'(ptr) + 1 + k, NUM_REQ));
            if (!found && eligible[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : apb_rr_arbiter
// Brief    : Round-robin arbiter sharing one APB master port among NUM_REQ
//            requesters; sequences SETUP/ACCESS and returns read data plus a
//            one-cycle done pulse to the winner.
// Options  : APB_ARB_TIMEOUT_EN - abort ACCESS after TIMEOUT_CYCLES wait cycles
//            and complete with err_o=1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic                      pready_i,
    input  logic [DATA_W-1:0]         prdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time guard on the supported parameter range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("apb_rr_arbiter: parameter out of supported range");
    end

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_write;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_REQ-1:0]  gnt;
    logic [NUM_REQ-1:0]  done;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                timeout_hit;
    logic                xfer_end;
    logic                start;

    // A requester still showing its done pulse is dropping req_i this edge.
    assign eligible = req_i & ~done;
    assign start    = (state == IDLE) && (|eligible);
    assign xfer_end = (state == ACCESS) && (pready_i || timeout_hit);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (win_onehot),
        .win_idx  (win_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Count ACCESS cycles without pready; restarts on every new transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!pready_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == ACCESS) && !pready_i &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (xfer_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, grant, pointer and completion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= IDX_W'(NUM_REQ - 1);
            cur_idx   <= '0;
            cur_write <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            done    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (start) begin
                gnt       <= win_onehot;
                cur_idx   <= win_idx;
                cur_write <= req_write_i[win_idx];
                addr_q    <= req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                wdata_q   <= req_write_i[win_idx] ?
                             req_wdata_i[int'(win_idx)*DATA_W +: DATA_W] : '0;
            end
            if (xfer_end) begin
                ptr     <= cur_idx;
                gnt     <= '0;
                done    <= gnt;
                rdata_q <= (cur_write || timeout_hit) ? '0 : prdata_i;
                err_q   <= timeout_hit;
            end
        end
    end

    assign gnt_o     = gnt;
    assign done_o    = done;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign psel_o    = (state == SETUP) || (state == ACCESS);
    assign penable_o = (state == ACCESS);
    assign pwrite_o  = cur_write;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_apb_rr_arbiter
// Brief    : Directed self-checking bench for apb_rr_arbiter (NUM_REQ=4).
//            The timeout scenario is compiled when APB_ARB_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pready;
    logic [DW-1:0]   prdata;

    int n_checks = 0;
    int n_fail   = 0;

    apb_rr_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .done_o      (done),
        .rdata_o     (rdata),
        .err_o       (err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pready_i    (pready),
        .prdata_i    (prdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;

        // ---- reset state
        tick(); tick();
        chk("rst_psel",    64'(psel),    64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_gnt",     64'(gnt),     64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        chk("rst_paddr",   64'(paddr),   64'd0);
        chk("rst_err",     64'(err),     64'd0);
        reset = 1'b0;

        // ---- 1: single read, req 2 @0x40, no waits, prdata 0xA5
        req_addr[2*AW +: AW] = 32'h40;
        req    = 4'b0100;
        pready = 1'b1;
        prdata = 32'hA5;
        tick();
        chk("t1_setup_gnt",     64'(gnt),     64'b0100);
        chk("t1_setup_psel",    64'(psel),    64'd1);
        chk("t1_setup_penable", 64'(penable), 64'd0);
        chk("t1_setup_paddr",   64'(paddr),   64'h40);
        chk("t1_setup_pwrite",  64'(pwrite),  64'd0);
        chk("t1_setup_pwdata",  64'(pwdata),  64'd0);
        tick();
        chk("t1_access_psel",    64'(psel),    64'd1);
        chk("t1_access_penable", 64'(penable), 64'd1);
        chk("t1_access_done",    64'(done),    64'd0);
        tick();
        chk("t1_done",      64'(done),  64'b0100);
        chk("t1_rdata",     64'(rdata), 64'hA5);
        chk("t1_err",       64'(err),   64'd0);
        chk("t1_end_psel",  64'(psel),  64'd0);
        chk("t1_end_gnt",   64'(gnt),   64'd0);
        req = '0;
        tick();
        chk("t1_done_clear",  64'(done),  64'd0);
        chk("t1_rdata_clear", 64'(rdata), 64'd0);
        chk("t1_no_regrant",  64'(psel),  64'd0);

        // ---- 2: reset (pointer back to N-1), all four held -> order 0,1,2,3,0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = 32'h100 + 32'(k*4);
        req    = 4'b1111;
        pready = 1'b1;
        prdata = 32'h55;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_gnt_%0d", i),   64'(gnt),   64'(4'b0001 << (i % 4)));
            chk($sformatf("t2_paddr_%0d", i), 64'(paddr), 64'(32'h100 + 32'((i % 4) * 4)));
            tick();
            chk($sformatf("t2_pen_%0d", i),   64'(penable), 64'd1);
            tick();
            chk($sformatf("t2_done_%0d", i),  64'(done), 64'(4'b0001 << (i % 4)));
            chk($sformatf("t2_gnt0_%0d", i),  64'(gnt),  64'd0);
            tick();
        end
        req = '0;
        // The ninth SETUP (req 0 again) is in flight; let it finish.
        tick(); tick(); tick();
        chk("t2_idle_psel", 64'(psel), 64'd0);

        // ---- 3: write, req 1 @0x10, wdata 0x1234, 5 wait states
        req_addr[1*AW +: AW]  = 32'h10;
        req_wdata[1*DW +: DW] = 32'h1234;
        req_write = 4'b0010;
        req       = 4'b0010;
        pready    = 1'b0;
        prdata    = 32'hDEAD;
        tick();
        chk("t3_setup_gnt",    64'(gnt),    64'b0010);
        chk("t3_setup_pwrite", 64'(pwrite), 64'd1);
        chk("t3_setup_pwdata", 64'(pwdata), 64'h1234);
        tick();
        for (int w = 0; w < 5; w++) begin
            chk($sformatf("t3_wait_pen_%0d", w),   64'(penable), 64'd1);
            chk($sformatf("t3_wait_paddr_%0d", w), 64'(paddr),   64'h10);
            chk($sformatf("t3_wait_wdata_%0d", w), 64'(pwdata),  64'h1234);
            chk($sformatf("t3_wait_done_%0d", w),  64'(done),    64'd0);
            tick();
        end
        pready = 1'b1;
        chk("t3_last_pen", 64'(penable), 64'd1);
        tick();
        chk("t3_done",  64'(done),  64'b0010);
        chk("t3_rdata", 64'(rdata), 64'd0);
        chk("t3_psel",  64'(psel),  64'd0);
        req       = '0;
        req_write = '0;
        tick();

        // ---- 4: req 3 changes address mid-transfer; latched copy stays on the bus
        req_addr[3*AW +: AW] = 32'h20;
        req    = 4'b1000;
        pready = 1'b0;
        prdata = 32'h77;
        tick();
        chk("t4_gnt",         64'(gnt),   64'b1000);
        chk("t4_setup_paddr", 64'(paddr), 64'h20);
        tick();
        req_addr[3*AW +: AW] = 32'h30;
        chk("t4_acc_paddr0", 64'(paddr), 64'h20);
        tick();
        chk("t4_acc_paddr1", 64'(paddr), 64'h20);
        pready = 1'b1;
        tick();
        chk("t4_done",  64'(done),  64'b1000);
        chk("t4_rdata", 64'(rdata), 64'h77);
        req = '0;
        tick();

        // ---- 5: reset during ACCESS, then next grant goes to req 0
        req    = 4'b0100;
        pready = 1'b0;
        tick();
        tick();
        chk("t5_in_access", 64'(penable), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_psel",    64'(psel),    64'd0);
        chk("t5_async_penable", 64'(penable), 64'd0);
        chk("t5_async_gnt",     64'(gnt),     64'd0);
        tick();
        chk("t5_no_done", 64'(done), 64'd0);
        reset  = 1'b0;
        req    = 4'b0101;
        pready = 1'b1;
        prdata = 32'h11;
        tick();
        chk("t5_next_gnt", 64'(gnt), 64'b0001);
        tick(); tick();
        chk("t5_done0", 64'(done), 64'b0001);
        req = 4'b0100;
        tick();
        chk("t5_gnt2", 64'(gnt), 64'b0100);
        tick(); tick();
        chk("t5_done2", 64'(done), 64'b0100);
        chk("t5_err",   64'(err),  64'd0);
        req = '0;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // ---- 6: pready stuck low -> abort after 16 ACCESS cycles, then next requester
        req    = 4'b0011;
        pready = 1'b0;
        prdata = 32'hFF;
        tick();
        chk("t6_gnt0", 64'(gnt), 64'b0001);
        tick();
        for (int c = 1; c < 16; c++) begin
            chk($sformatf("t6_wait_pen_%0d", c),  64'(penable), 64'd1);
            chk($sformatf("t6_wait_done_%0d", c), 64'(done),    64'd0);
            tick();
        end
        chk("t6_last_pen", 64'(penable), 64'd1);
        tick();
        chk("t6_done",  64'(done),  64'b0001);
        chk("t6_err",   64'(err),   64'd1);
        chk("t6_rdata", 64'(rdata), 64'd0);
        chk("t6_psel",  64'(psel),  64'd0);
        req    = 4'b0010;
        pready = 1'b1;
        tick();
        chk("t6_next_gnt", 64'(gnt), 64'b0010);
        tick(); tick();
        chk("t6_next_done", 64'(done), 64'b0010);
        chk("t6_next_err",  64'(err),  64'd0);
        req = '0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
